// File: rtl/mux_8ch_arbiter.sv
// Round-robin arbiter that drives an 8:1 mux: select, settle, then grant one channel.
// Optional feature: define MUX_ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module mux_8ch_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned HOLD_MAX      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       s_n,
  output logic       a2,
  output logic       a1,
  output logic       a0,
  output logic [7:0] grant,
  output logic       busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] sel;
  logic [2:0] ptr;
  logic [3:0] settle_cnt;
  logic       release_now;

  // First set request bit at or above p, wrapping 7->0. Scanning from the
  // farthest offset down lets the nearest hit overwrite the result last.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign {a2, a1, a0} = sel;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  assign release_now = done || !req[sel] || (hold_cnt == HOLD_LAST);
`else
  assign release_now = done || !req[sel];
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 3'd0;
      ptr        <= 3'd0;
      settle_cnt <= 4'd0;
      s_n        <= 1'b1;
      grant      <= 8'd0;
      busy       <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req != 8'd0) begin
            sel        <= pick(req, ptr);
            settle_cnt <= SETTLE_LOAD;
            s_n        <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!req[sel]) begin
            // Abandoned before grant: the pointer stays put so this slot is retried fairly.
            settle_cnt <= 4'd0;
            s_n        <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (settle_cnt == 4'd0) begin
            grant      <= 8'd1 << sel;
            state      <= GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt   <= 8'd0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr   <= sel + 3'd1;
            s_n   <= 1'b1;
            grant <= 8'd0;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: begin
          s_n   <= 1'b1;
          grant <= 8'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_8ch_arbiter.md
MUX_8CH_ARBITER -- requirements
Module: mux_8ch_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles between select change and grant, covering 8:1 mux propagation; legal range 1..15.
REQ-002 SHALL have parameter HOLD_MAX, default 255: maximum cycles a grant is held; legal range 1..255; used only under MUX_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  8  channel requests; bit i requests mux input di.
REQ-006 SHALL have port done  input  1  current grantee releases the mux.
REQ-007 SHALL have port s_n  output  1  mux strobe, active-low; drives the mux enable.
REQ-008 SHALL have ports a2, a1, a0  output  1 each  mux select; {a2,a1,a0} equals the granted channel index.
REQ-009 SHALL have port grant  output  8  one-hot grant; all zero when no grant.
REQ-010 SHALL have port busy  output  1  high in SETTLE and GRANT states.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SETTLE, GRANT.
REQ-012 In IDLE, SHALL hold s_n=1, grant=0, busy=0, and {a2,a1,a0} at its last value.
REQ-013 In IDLE with req!=0 at a rising edge, SHALL select the first set req bit searching upward from pointer ptr with wrap 7->0, load {a2,a1,a0} with its index, drive s_n=0, load settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-014 In SETTLE, SHALL decrement the counter each cycle and enter GRANT on the edge where the counter is 0; grant[sel] rises SETTLE_CYCLES cycles after s_n falls.
REQ-015 {a2,a1,a0} SHALL NOT change while s_n=0.
REQ-016 In GRANT, SHALL hold grant[sel]=1 and s_n=0 until done=1 or req[sel]=0 is sampled, then enter IDLE with ptr=(sel+1) mod 8.
REQ-017 If req[sel] drops during SETTLE, SHALL return to IDLE without granting and leave ptr unchanged.
REQ-018 Between consecutive grants, SHALL spend at least one cycle in IDLE with s_n=1 and grant=0.
REQ-019 If done and a new req are sampled in the same cycle, release SHALL take priority, and the new req SHALL be arbitrated in the following IDLE cycle.
REQ-020 done SHALL be ignored outside GRANT.
REQ-021 At most one grant bit SHALL be set at any time.

Reset
REQ-022 While rst_n=0, outputs SHALL be s_n=1, {a2,a1,a0}=000, grant=0, busy=0, with state IDLE, ptr=0, and counters 0.
REQ-023 Reset asserted mid-SETTLE or mid-GRANT SHALL force the reset values immediately, without waiting for clk.
REQ-024 After rst_n deasserts, arbitration SHALL begin on the first rising edge with req!=0.

Configuration
REQ-025 With MUX_ARB_TIMEOUT_EN defined, SHALL count cycles in GRANT and force release to IDLE (ptr=sel+1) on the edge after HOLD_MAX cycles of grant, even with req[sel]=1 and done=0.
REQ-026 Without MUX_ARB_TIMEOUT_EN, SHALL include no hold counter, and a grant SHALL persist until done or req drop.

Verification
REQ-027 Reset, then req=8'b0000_0100 with SETTLE_CYCLES=2 -> s_n=0, {a2,a1,a0}=010 one edge later; grant=8'b0000_0100 two edges after that; busy=1 throughout.
REQ-028 req=8'hFF held, done pulsed once per grant -> grant order 0,1,2,...,7,0, with exactly one IDLE cycle (s_n=1) between grants.
REQ-029 In GRANT on channel 3, done=1 and req[5] newly set in the same cycle -> IDLE for one cycle, then select 101 and grant bit 5.
REQ-030 req[6] dropped during SETTLE -> IDLE, grant stays 0, ptr unchanged; next req=8'h41 grants channel 0 if ptr=0.
REQ-031 rst_n pulled low mid-GRANT between clock edges -> s_n=1, grant=0, select=000 immediately; after release, req=8'h80 grants channel 7.
REQ-032 With MUX_ARB_TIMEOUT_EN and HOLD_MAX=4, req=8'h03 held, done=0 -> channel 0 is released after 4 grant cycles, then channel 1 is granted.
